// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiplier/divider: FSM state encoding,
// mode encoding and the iteration-counter width.
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Counter must hold A_WIDTH itself, not just A_WIDTH-1.
  function automatic int cnt_width(input int a_width);
    return $clog2(a_width + 1);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration of shift-add multiply or restoring divide,
// built around a single shared add/subtract unit.
module mul_div_addsub #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);
  logic [W-1:0] w_y;

  // Subtraction as x + ~y + 1; carry out high means no borrow.
  assign w_y = i_sub ? ~i_y : i_y;
  assign {o_carry, o_sum} = {1'b0, i_x} + {1'b0, w_y} + {{W{1'b0}}, i_sub};
endmodule

module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int B_WIDTH = 3
) (
  input  logic               i_mode,
  input  logic [B_WIDTH:0]   i_acc,
  input  logic               i_a_bit,
  input  logic [B_WIDTH-1:0] i_oper,
  output logic [B_WIDTH:0]   o_acc,
  output logic               o_bit
);
  logic [B_WIDTH:0] w_x;
  logic [B_WIDTH:0] w_sum;
  logic             w_carry;
  logic [B_WIDTH:0] w_mul_s;

  // Divide shifts the next dividend bit into the partial remainder first.
  assign w_x = (i_mode == MODE_DIV) ? {i_acc[B_WIDTH-1:0], i_a_bit} : i_acc;

  mul_div_addsub #(.W(B_WIDTH + 1)) u_addsub (
    .i_x     (w_x),
    .i_y     ({1'b0, i_oper}),
    .i_sub   (i_mode),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_mul_s = i_a_bit ? w_sum : i_acc;

  always_comb begin
    o_acc = '0;
    o_bit = 1'b0;
    if (i_mode == MODE_DIV) begin
      if (w_carry) begin
        o_acc = w_sum;
        o_bit = 1'b1;
      end else begin
        o_acc = w_x;
        o_bit = 1'b0;
      end
    end else begin
      o_acc = {1'b0, w_mul_s[B_WIDTH:1]};
      o_bit = w_mul_s[0];
    end
  end
endmodule

// File: rtl/seq_mul_div.sv
// Iterative unsigned multiplier/divider retiring one operand bit per cycle.
// Start is sampled in IDLE/DONE; Valid is a one-cycle pulse while in DONE.
module seq_mul_div
  import mul_div_pkg::*;
#(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Start,
  input  logic                       Div_nMul,
  input  logic [A_WIDTH-1:0]         OperA,
  input  logic [B_WIDTH-1:0]         OperB,
  input  logic [B_WIDTH-1:0]         OperD,
  output logic                       Busy,
  output logic                       Valid,
  output logic [A_WIDTH+B_WIDTH-1:0] Result,
  output logic [B_WIDTH-1:0]         Remainder,
  output logic                       DivZero,
  output logic [1:0]                 Dbg_State
);
  localparam int CW = cnt_width(A_WIDTH);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]                   r_state;
  logic [CW-1:0]                r_cnt;
  logic                         r_mode;
  logic [B_WIDTH:0]             r_acc;
  logic [A_WIDTH-1:0]           r_a;
  logic [B_WIDTH-1:0]           r_oper;
  logic [A_WIDTH+B_WIDTH-1:0]   r_result;
  logic [B_WIDTH-1:0]           r_rem;
  logic                         r_divzero;

  logic               w_a_bit;
  logic [B_WIDTH:0]   w_acc_nx;
  logic               w_bit;
  logic [A_WIDTH-1:0] w_a_nx;
  logic               w_accept;
  logic               w_dz_req;

  // Multiply consumes A from the LSB end; divide from the MSB end, with
  // quotient bits filling in behind.
  assign w_a_bit = r_mode ? r_a[A_WIDTH-1] : r_a[0];
  assign w_a_nx  = r_mode ? {r_a[A_WIDTH-2:0], w_bit} : {w_bit, r_a[A_WIDTH-1:1]};

  mul_div_step #(.B_WIDTH(B_WIDTH)) u_step (
    .i_mode  (r_mode),
    .i_acc   (r_acc),
    .i_a_bit (w_a_bit),
    .i_oper  (r_oper),
    .o_acc   (w_acc_nx),
    .o_bit   (w_bit)
  );

  assign w_accept = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dz_req = (Div_nMul == MODE_DIV) && (OperD == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mode    <= MODE_MUL;
      r_acc     <= '0;
      r_a       <= '0;
      r_oper    <= '0;
      r_result  <= '0;
      r_rem     <= '0;
      r_divzero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept && w_dz_req) begin
            r_state   <= S_DONE;
            r_result  <= {{B_WIDTH{1'b0}}, {A_WIDTH{1'b1}}};
            r_rem     <= '0;
            r_divzero <= 1'b1;
          end else if (w_accept) begin
            r_state <= S_RUN;
            r_mode  <= Div_nMul;
            r_oper  <= Div_nMul ? OperD : OperB;
            r_a     <= OperA;
            r_acc   <= '0;
            r_cnt   <= CW'(A_WIDTH);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nx;
          r_a   <= w_a_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state   <= S_DONE;
            r_divzero <= 1'b0;
            if (r_mode == MODE_DIV) begin
              r_result <= {{B_WIDTH{1'b0}}, w_a_nx};
              r_rem    <= w_acc_nx[B_WIDTH-1:0];
            end else begin
              r_result <= {w_acc_nx[B_WIDTH-1:0], w_a_nx};
              r_rem    <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy      = (r_state == S_RUN);
  assign Valid     = (r_state == S_DONE);
  assign Result    = r_result;
  assign Remainder = r_rem;
  assign DivZero   = r_divzero;
  assign Dbg_State = r_state;
endmodule
